// File: rtl/voice_allocator_if.sv
// Event and voice-bus bundle between the note source (master) and voice_allocator (slave).
// The carrier and modulator buses pack slot k at [k*NUM_BITS +: NUM_BITS].
interface voice_allocator_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int NOTE_BITS    = 7
);
    logic                             evt_valid;
    logic                             evt_ready;
    logic                             evt_note_on;
    logic [NOTE_BITS-1:0]             evt_note;
    logic [3:0]                       mod_ratio;
    logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out;
    logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out;
    logic [NUM_CHANNELS-1:0]          active;
    logic                             drop;

    modport master (
        output evt_valid, evt_note_on, evt_note, mod_ratio,
        input  evt_ready, carrier_out, modulator_out, active, drop
    );

    modport slave (
        input  evt_valid, evt_note_on, evt_note, mod_ratio,
        output evt_ready, carrier_out, modulator_out, active, drop
    );
endinterface

// File: rtl/voice_allocator.sv
// Note-event front end for the synth core: ROM lookup of the carrier word, ratio-scaled
// modulator word, and lowest-free-slot voice allocation with note-off release.
module voice_allocator #(
    parameter string TUNING_WORDS = "tuning.mem",
    parameter int    NUM_CHANNELS = 16,
    parameter int    NUM_BITS     = 32,
    parameter int    NOTE_BITS    = 7,
    parameter logic [NUM_BITS-1:0] TUNING_INIT [2**NOTE_BITS] = '{default: '0}
) (
    input logic              clk,
    input logic              rst,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, ALLOC} state_e;

    state_e                  state_q, state_d;
    logic [NOTE_BITS-1:0]    note_q, note_d;
    logic                    on_q, on_d;
    logic                    drop_q, drop_d;
    logic [NUM_CHANNELS-1:0] active_q, active_d;
    logic [NUM_BITS-1:0]     carrier_q [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     carrier_d [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     mod_q     [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     mod_d     [NUM_CHANNELS];
    logic [NOTE_BITS-1:0]    tag_q     [NUM_CHANNELS];
    logic [NOTE_BITS-1:0]    tag_d     [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     rom_data_q;

    // NOTE: the ROM and its read register carry no reset so the pair can map onto block RAM;
    // only the slot bank, tags and FSM are reset.
    always_ff @(posedge clk) begin
        rom_data_q <= TUNING_INIT[note_q];
    end

    // Modulator word: carrier * Q2.2 ratio, drop the two fraction bits, saturate on overflow.
    logic [NUM_BITS+3:0] prod;
    logic [NUM_BITS+1:0] mod_full;
    logic [NUM_BITS-1:0] mod_word;

    always_comb begin
        prod     = (NUM_BITS+4)'(rom_data_q) * (NUM_BITS+4)'(bus.mod_ratio);
        mod_full = (NUM_BITS+2)'(prod >> 2);
        mod_word = (|mod_full[NUM_BITS+1:NUM_BITS]) ? '1 : mod_full[NUM_BITS-1:0];
    end

    logic             hit_found, free_found;
    logic [IDX_W-1:0] hit_idx, free_idx;

    // Descending scan so the last match written is the lowest index.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (active_q[k] && (tag_q[k] == note_q)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(k);
            end
            if (!active_q[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end
    end

    // NOTE: always_comb assigns every output a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        on_d      = on_q;
        drop_d    = 1'b0;
        active_d  = active_q;
        carrier_d = carrier_q;
        mod_d     = mod_q;
        tag_d     = tag_q;

        unique case (state_q)
            IDLE: begin
                if (bus.evt_valid) begin
                    note_d  = bus.evt_note;
                    on_d    = bus.evt_note_on;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = ALLOC;
            ALLOC: begin
                state_d = IDLE;
                if (on_q) begin
                    if (hit_found) begin
                        carrier_d[hit_idx] = rom_data_q;
                        mod_d[hit_idx]     = mod_word;
                    end else if (free_found) begin
                        carrier_d[free_idx] = rom_data_q;
                        mod_d[free_idx]     = mod_word;
                        active_d[free_idx]  = 1'b1;
                        tag_d[free_idx]     = note_q;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (hit_found) begin
                    carrier_d[hit_idx] = '0;
                    mod_d[hit_idx]     = '0;
                    active_d[hit_idx]  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            note_q   <= '0;
            on_q     <= 1'b0;
            drop_q   <= 1'b0;
            active_q <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                carrier_q[k] <= '0;
                mod_q[k]     <= '0;
                tag_q[k]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            on_q      <= on_d;
            drop_q    <= drop_d;
            active_q  <= active_d;
            carrier_q <= carrier_d;
            mod_q     <= mod_d;
            tag_q     <= tag_d;
        end
    end

    assign bus.evt_ready = (state_q == IDLE);
    assign bus.active    = active_q;
    assign bus.drop      = drop_q;

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_pack
        assign bus.carrier_out[k*NUM_BITS +: NUM_BITS]   = carrier_q[k];
        assign bus.modulator_out[k*NUM_BITS +: NUM_BITS] = mod_q[k];
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed and randomized checks of voice_allocator against a slot-table reference model.
// Bench ROM: rom[n] = n << 20, except rom[127] = 32'hF0000000.
module tb_voice_allocator;
    localparam int NCH = 16;

    typedef logic [31:0] rom_t [128];

    function automatic logic [31:0] rom_word(input int n);
        return (n == 127) ? 32'hF0000000 : (32'(n) << 20);
    endfunction

    function automatic rom_t make_rom();
        rom_t r;
        for (int n = 0; n < 128; n++) r[n] = rom_word(n);
        return r;
    endfunction

    localparam rom_t BENCH_ROM = make_rom();

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_CHANNELS(NCH), .NUM_BITS(32), .NOTE_BITS(7)) vif ();

    voice_allocator #(
        .TUNING_WORDS (""),
        .NUM_CHANNELS (NCH),
        .NUM_BITS     (32),
        .NOTE_BITS    (7),
        .TUNING_INIT  (BENCH_ROM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0] m_car [NCH];
    logic [31:0] m_mod [NCH];
    bit          m_act [NCH];
    int          m_tag [NCH];
    bit          m_drop;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_mod(input logic [31:0] c, input int r);
        longint unsigned m;
        m = (64'(c) * 64'(r)) / 4;
        return (m > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFFFFFF : m[31:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_car[k] = '0;
            m_mod[k] = '0;
            m_act[k] = 1'b0;
            m_tag[k] = 0;
        end
        m_drop = 1'b0;
    endtask

    task automatic model_apply(input bit on, input int note, input int ratio);
        int s;
        s = -1;
        m_drop = 1'b0;
        for (int k = 0; k < NCH && s < 0; k++)
            if (m_act[k] && m_tag[k] == note) s = k;
        if (on) begin
            for (int k = 0; k < NCH && s < 0; k++)
                if (!m_act[k]) s = k;
            if (s < 0) begin
                m_drop = 1'b1;
            end else begin
                m_car[s] = rom_word(note);
                m_mod[s] = model_mod(rom_word(note), ratio);
                m_act[s] = 1'b1;
                m_tag[s] = note;
            end
        end else if (s >= 0) begin
            m_car[s] = '0;
            m_mod[s] = '0;
            m_act[s] = 1'b0;
        end
    endtask

    task automatic check_all(input string step);
        logic [511:0] ec, em;
        logic [15:0]  ea;
        for (int k = 0; k < NCH; k++) begin
            ec[k*32 +: 32] = m_car[k];
            em[k*32 +: 32] = m_mod[k];
            ea[k]          = m_act[k];
        end
        check({step, " carrier"}, vif.carrier_out, ec);
        check({step, " modulator"}, vif.modulator_out, em);
        check({step, " active"}, vif.active, ea);
        check({step, " drop"}, vif.drop, m_drop);
        check({step, " ready"}, vif.evt_ready, 1'b1);
    endtask

    // One event: handshake at edge N, outputs compared #1 after edge N+2.
    task automatic send(input string step, input bit on, input int note, input int ratio);
        int guard;
        guard = 0;
        while (vif.evt_ready !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check({step, " ready_wait"}, vif.evt_ready, 1'b1);
        vif.evt_valid   = 1'b1;
        vif.evt_note_on = on;
        vif.evt_note    = 7'(note);
        vif.mod_ratio   = 4'(ratio);
        @(posedge clk); #1;
        vif.evt_valid   = 1'b0;
        vif.evt_note_on = 1'($urandom);
        vif.evt_note    = 7'($urandom);
        @(posedge clk);
        @(posedge clk); #1;
        model_apply(on, note, ratio);
        check_all(step);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        model_reset();
        vif.evt_valid   = 1'b0;
        vif.evt_note_on = 1'b0;
        vif.evt_note    = '0;
        vif.mod_ratio   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Reset while the event is in ALLOC discards it.
        @(posedge clk); #1;
        vif.evt_valid   = 1'b1;
        vif.evt_note_on = 1'b1;
        vif.evt_note    = 7'd69;
        vif.mod_ratio   = 4'b0110;
        @(posedge clk); #1;
        vif.evt_valid = 1'b0;
        check("mid fetch busy", vif.evt_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all("mid_alloc_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("after_reset");

        send("t2", 1'b1, 69, 6);
        check("t2 slot0 carrier", vif.carrier_out[31:0], 32'h04500000);
        check("t2 slot0 modulator", vif.modulator_out[31:0], 32'h06780000);
        check("t2 active", vif.active, 16'h0001);

        send("t3 clear69", 1'b0, 69, 0);
        for (int n = 1; n <= 16; n++) send("t3 fill", 1'b1, n, 4);
        check("t3 full", vif.active, 16'hFFFF);
        send("t3 overflow", 1'b1, 20, 4);
        check("t3 drop pulse", vif.drop, 1'b1);
        @(posedge clk); #1;
        m_drop = 1'b0;
        check_all("t3 drop gone");

        send("t4 off5", 1'b0, 5, 4);
        check("t4 slot4 carrier", vif.carrier_out[4*32 +: 32], 32'h0);
        check("t4 active4", vif.active[4], 1'b0);
        send("t4 on40", 1'b1, 40, 4);
        check("t4 slot4 carrier40", vif.carrier_out[4*32 +: 32], 32'h02800000);

        send("t5 off1", 1'b0, 1, 4);
        send("t5 on69", 1'b1, 69, 6);
        send("t5 dup69", 1'b1, 69, 8);
        check("t5 slot0 modulator", vif.modulator_out[31:0], 32'h08A00000);
        check("t5 active", vif.active, 16'hFFFF);
        send("t5 off99", 1'b0, 99, 4);
        check("t5 no drop", vif.drop, 1'b0);

        // Back-to-back: evt_valid held high across two note-ons of 127.
        send("t6 off2", 1'b0, 2, 4);
        vif.evt_valid   = 1'b1;
        vif.evt_note_on = 1'b1;
        vif.evt_note    = 7'd127;
        vif.mod_ratio   = 4'd8;
        @(posedge clk); #1;
        low = 0;
        while (vif.evt_ready !== 1'b1 && low < 10) begin
            low++;
            @(posedge clk); #1;
        end
        check("t6 ready low cycles", low, 2);
        model_apply(1'b1, 127, 8);
        check_all("t6 first");
        check("t6 saturate", vif.modulator_out[1*32 +: 32], 32'hFFFFFFFF);
        @(posedge clk); #1;
        vif.evt_valid = 1'b0;
        check("t6 second busy", vif.evt_ready, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        model_apply(1'b1, 127, 8);
        check_all("t6 second");

        // Randomized traffic over a small note pool to force hits, misses and drops.
        for (int i = 0; i < 60; i++) begin
            int note;
            note = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 23));
            send("rand", ($urandom_range(0, 2) != 0), note, int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
